adder_sweep_monitor: RTL and testbench

Self-timed characterisation stage for the small carry-lookahead/approximate adder models. On `start` it drives every operand pair of a W-bit adder onto shared operand buses; the exact model and the approximate model under test both compute from these buses combinationally. It samples both sums on the same cycle and accumulates the error metrics: error count, summed absolute error and maximum absolute error. It sits directly upstream of the adders, as their operand source, and directly downstream of them, as their result consumer.

---
 rtl/adder_char_pkg.sv | 24 ++
 rtl/adder_sweep_monitor_abs_diff.sv | 13 +
 rtl/adder_sweep_monitor.sv | 93 +++++++++
 tb/tb_adder_sweep_monitor.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/adder_char_pkg.sv
// Shared types and width helpers for the adder characterisation slice.
// Widths are derived from the adder operand width W.
package adder_char_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SWEEP,
    DRAIN,
    DONE
  } state_t;

  function automatic int sum_w(input int w);
    return w + 1;
  endfunction

  function automatic int cnt_w(input int w);
    return 2 * w + 1;
  endfunction

  function automatic int err_w(input int w);
    return 3 * w + 1;
  endfunction

endpackage

// File: rtl/adder_sweep_monitor_abs_diff.sv
// Combinational absolute difference of two unsigned values.
// Larger minus smaller, so the result never underflows.
module abs_diff #(
  parameter int N = 3
) (
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  output logic [N-1:0] d
);

  assign d = (x >= y) ? (x - y) : (y - x);

endmodule

// File: rtl/adder_sweep_monitor.sv
// Sweeps every operand pair through exact/approximate adders and
// accumulates error count, summed and maximum absolute error.
module adder_sweep_monitor
  import adder_char_pkg::*;
#(
  parameter int W = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  output logic [W-1:0]   a_o,
  output logic [W-1:0]   b_o,
  input  logic [W:0]     y_exact_i,
  input  logic [W:0]     y_approx_i,
  output logic           busy,
  output logic           done,
  output logic [2*W:0]   err_count,
  output logic [3*W:0]   sum_abs_err,
  output logic [W:0]     max_abs_err
);

  localparam int SW = sum_w(W);
  localparam int CW = cnt_w(W);
  localparam int EW = err_w(W);
  localparam logic [2*W-1:0] LAST = '1;

  state_t          state;
  logic [2*W-1:0]  idx;
  logic            v1;
  logic [SW-1:0]   diff_d;
  logic [SW-1:0]   diff_q;

  abs_diff #(.N(SW)) u_abs_diff (
    .x (y_approx_i),
    .y (y_exact_i),
    .d (diff_d)
  );

  assign a_o = idx[W-1:0];
  assign b_o = idx[2*W-1:W];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      idx         <= '0;
      v1          <= 1'b0;
      diff_q      <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err_count   <= '0;
      sum_abs_err <= '0;
      max_abs_err <= '0;
    end else begin
      if (v1) begin
        err_count   <= err_count + CW'(diff_q != '0);
        sum_abs_err <= sum_abs_err + EW'(diff_q);
        if (diff_q > max_abs_err)
          max_abs_err <= diff_q;
      end
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            state       <= SWEEP;
            idx         <= '0;
            v1          <= 1'b0;
            busy        <= 1'b1;
            done        <= 1'b0;
            err_count   <= '0;
            sum_abs_err <= '0;
            max_abs_err <= '0;
          end
        end
        SWEEP: begin
          diff_q <= diff_d;
          v1     <= 1'b1;
          if (idx == LAST)
            state <= DRAIN;
          else
            idx <= idx + 1'b1;
        end
        DRAIN: begin
          // last diff is accumulated on this edge
          v1    <= 1'b0;
          state <= DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adder_sweep_monitor.sv
// Self-checking bench for adder_sweep_monitor with W=2.
// Exact/approximate adders are modelled here; results go through a scoreboard.
module tb_adder_sweep_monitor;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [1:0] a_o, b_o;
  logic [2:0] y_exact, y_approx;
  logic       busy, done;
  logic [4:0] err_count;
  logic [6:0] sum_abs_err;
  logic [2:0] max_abs_err;
  int         mode = 0;
  int         n_checks = 0;
  int         n_fail = 0;

  typedef struct {
    int ec;
    int sae;
    int mae;
  } exp_t;

  exp_t sb[$];
  int   vq[$];

  adder_sweep_monitor #(.W(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .a_o         (a_o),
    .b_o         (b_o),
    .y_exact_i   (y_exact),
    .y_approx_i  (y_approx),
    .busy        (busy),
    .done        (done),
    .err_count   (err_count),
    .sum_abs_err (sum_abs_err),
    .max_abs_err (max_abs_err)
  );

  always #5 clk = ~clk;

  always_comb begin
    y_exact  = {1'b0, a_o} + {1'b0, b_o};
    y_approx = y_exact;
    if (mode == 1)
      y_approx[0] = 1'b0;
    else if (mode == 2)
      y_approx[2] = 1'b0;
  end

  function automatic int approx_of(input int m, input int s);
    if (m == 1) return s & ~1;
    if (m == 2) return s & ~4;
    return s;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({a_o, b_o, busy, done} !== 6'd0 || err_count !== 5'd0 ||
        sum_abs_err !== 7'd0 || max_abs_err !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_state: a=%0d b=%0d busy=%0b done=%0b ec=%0d sae=%0d mae=%0d want all 0",
               a_o, b_o, busy, done, err_count, sum_abs_err, max_abs_err);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic run_sweep(input int m, input bit hold, input string tag);
    exp_t e;
    exp_t g;
    int   done_cyc;
    int   v;
    int   d;
    mode = m;
    e.ec = 0; e.sae = 0; e.mae = 0;
    for (int b = 0; b < 4; b++)
      for (int a = 0; a < 4; a++) begin
        d = approx_of(m, a + b) - (a + b);
        if (d < 0) d = -d;
        if (d != 0) e.ec++;
        e.sae += d;
        if (d > e.mae) e.mae = d;
      end
    sb.push_back(e);
    for (int i = 0; i < 16; i++)
      vq.push_back(i);
    start = 1'b1;
    done_cyc = -1;
    for (int c = 1; c <= 40 && done_cyc < 0; c++) begin
      @(negedge clk);
      if (c == 1) begin
        n_checks++;
        if (done !== 1'b0 || err_count !== 5'd0 || sum_abs_err !== 7'd0 ||
            max_abs_err !== 3'd0) begin
          n_fail++;
          $display("FAIL %s start_clear: done=%0b ec=%0d sae=%0d mae=%0d want 0",
                   tag, done, err_count, sum_abs_err, max_abs_err);
        end
        if (!hold) start = 1'b0;
      end
      if (c <= 16) begin
        v = vq.pop_front();
        n_checks++;
        if (busy !== 1'b1 || {28'd0, b_o, a_o} !== v) begin
          n_fail++;
          $display("FAIL %s vector c%0d: busy=%0b a=%0d b=%0d want busy=1 a=%0d b=%0d",
                   tag, c, busy, a_o, b_o, v % 4, v / 4);
        end
      end
      if (c == 17) begin
        n_checks++;
        if (busy !== 1'b1 || done !== 1'b0 || a_o !== 2'd3 || b_o !== 2'd3) begin
          n_fail++;
          $display("FAIL %s drain: busy=%0b done=%0b a=%0d b=%0d want 1 0 3 3",
                   tag, busy, done, a_o, b_o);
        end
        start = 1'b0;
      end
      if (done === 1'b1) done_cyc = c;
    end
    start = 1'b0;
    n_checks++;
    if (done_cyc != 18) begin
      n_fail++;
      $display("FAIL %s done_latency: got cycle %0d want 18", tag, done_cyc);
    end
    g = sb.pop_front();
    n_checks++;
    if (err_count !== g.ec[4:0] || sum_abs_err !== g.sae[6:0] ||
        max_abs_err !== g.mae[2:0] || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s metrics: ec=%0d sae=%0d mae=%0d busy=%0b want %0d %0d %0d 0",
               tag, err_count, sum_abs_err, max_abs_err, busy, g.ec, g.sae, g.mae);
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if (done !== 1'b1 || err_count !== g.ec[4:0]) begin
      n_fail++;
      $display("FAIL %s done_hold: done=%0b ec=%0d want 1 %0d",
               tag, done, err_count, g.ec);
    end
  endtask

  task automatic test_exact();
    run_sweep(0, 1'b0, "exact");
  endtask

  task automatic test_lsb_drop();
    run_sweep(1, 1'b0, "lsb_drop");
  endtask

  task automatic test_carry_drop();
    run_sweep(2, 1'b0, "carry_drop");
  endtask

  task automatic test_restart_in_done();
    run_sweep(2, 1'b0, "restart");
  endtask

  task automatic test_hold_start();
    run_sweep(1, 1'b1, "hold_start");
  endtask

  task automatic test_reset_mid_sweep();
    mode = 1;
    start = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
    end
    n_checks++;
    if (busy !== 1'b1 || a_o !== 2'd2 || b_o !== 2'd1) begin
      n_fail++;
      $display("FAIL mid_pre: busy=%0b a=%0d b=%0d want 1 2 1", busy, a_o, b_o);
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if ({a_o, b_o, busy, done} !== 6'd0 || err_count !== 5'd0 ||
        sum_abs_err !== 7'd0 || max_abs_err !== 3'd0) begin
      n_fail++;
      $display("FAIL mid_reset: a=%0d b=%0d busy=%0b done=%0b ec=%0d sae=%0d mae=%0d want all 0",
               a_o, b_o, busy, done, err_count, sum_abs_err, max_abs_err);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_sweep(2, 1'b0, "after_reset");
  endtask

  initial begin
    test_reset();
    test_exact();
    test_lsb_drop();
    test_carry_drop();
    test_restart_in_done();
    test_reset_mid_sweep();
    test_hold_start();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
